// File: rtl/control_stage_pipeline.sv
// Control-bundle pipeline from Decode through Execute, Memory and Writeback.
// Carries the decoded control fields stage by stage, gates each stage's
// side-effect enables with that stage's valid bit, stalls Decode for one
// cycle on a load-use dependency (inserting a bubble into Execute), and
// counts retired output-flag operations.
module control_stage_pipeline #(
    parameter int REG_ADDR_WIDTH = 4,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      validD,
    input  logic                      isScalarInstructionD,
    input  logic                      isVectorScalarOperationD,
    input  logic                      useInmediateD,
    input  logic [2:0]                aluControlD,
    input  logic                      writeToMemoryEnableD,
    input  logic                      outFlagD,
    input  logic                      resultSelectorD,
    input  logic                      writeEnableScalarD,
    input  logic                      writeEnableVectorD,
    input  logic [REG_ADDR_WIDTH-1:0] rdD,
    input  logic [REG_ADDR_WIDTH-1:0] rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] rs2D,
    input  logic                      holdAll,
    output logic                      stallD,
    output logic                      validE,
    output logic                      isScalarInstructionE,
    output logic                      isVectorScalarOperationE,
    output logic                      useInmediateE,
    output logic [2:0]                aluControlE,
    output logic                      validM,
    output logic                      writeToMemoryEnableM,
    output logic                      outFlagM,
    output logic                      validW,
    output logic                      resultSelectorW,
    output logic                      writeEnableScalarW,
    output logic                      writeEnableVectorW,
    output logic [REG_ADDR_WIDTH-1:0] rdW,
    output logic [COUNT_WIDTH-1:0]    outFlagCount
);

    // Execute-stage fields that are not exported but travel onward
    logic                      writeToMemoryEnableE;
    logic                      outFlagE;
    logic                      resultSelectorE;
    logic                      writeEnableScalarE;
    logic                      writeEnableVectorE;
    logic [REG_ADDR_WIDTH-1:0] rdE;

    // Memory-stage fields that travel on to Writeback
    logic                      resultSelectorM;
    logic                      writeEnableScalarM;
    logic                      writeEnableVectorM;
    logic [REG_ADDR_WIDTH-1:0] rdM;

    logic hazard;
    logic loadD;

    // A memory-result producer in Execute whose destination matches either
    // Decode source forces one bubble. Address-only match: deliberately
    // conservative, it may stall on a scalar/vector name collision.
    assign hazard = validD & validE & resultSelectorE
                  & (writeEnableScalarE | writeEnableVectorE)
                  & ((rs1D == rdE) | (rs2D == rdE));

    assign stallD = hazard | holdAll;

    // Decode content is only captured when it is a real instruction and no bubble is due
    assign loadD = validD & ~hazard;

    // Execute stage: capture Decode, or a zeroed bubble on hazard / invalid Decode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validE                   <= 1'b0;
            isScalarInstructionE     <= 1'b0;
            isVectorScalarOperationE <= 1'b0;
            useInmediateE            <= 1'b0;
            aluControlE              <= '0;
            writeToMemoryEnableE     <= 1'b0;
            outFlagE                 <= 1'b0;
            resultSelectorE          <= 1'b0;
            writeEnableScalarE       <= 1'b0;
            writeEnableVectorE       <= 1'b0;
            rdE                      <= '0;
        end else if (!holdAll) begin
            validE                   <= loadD;
            isScalarInstructionE     <= loadD & isScalarInstructionD;
            isVectorScalarOperationE <= loadD & isVectorScalarOperationD;
            useInmediateE            <= loadD & useInmediateD;
            aluControlE              <= loadD ? aluControlD : 3'b000;
            writeToMemoryEnableE     <= loadD & writeToMemoryEnableD;
            outFlagE                 <= loadD & outFlagD;
            resultSelectorE          <= loadD & resultSelectorD;
            writeEnableScalarE       <= loadD & writeEnableScalarD;
            writeEnableVectorE       <= loadD & writeEnableVectorD;
            rdE                      <= loadD ? rdD : '0;
        end
    end

    // Memory stage: take Execute, storing side-effect enables gated by valid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validM               <= 1'b0;
            writeToMemoryEnableM <= 1'b0;
            outFlagM             <= 1'b0;
            resultSelectorM      <= 1'b0;
            writeEnableScalarM   <= 1'b0;
            writeEnableVectorM   <= 1'b0;
            rdM                  <= '0;
        end else if (!holdAll) begin
            validM               <= validE;
            writeToMemoryEnableM <= validE & writeToMemoryEnableE;
            outFlagM             <= validE & outFlagE;
            resultSelectorM      <= resultSelectorE;
            writeEnableScalarM   <= writeEnableScalarE;
            writeEnableVectorM   <= writeEnableVectorE;
            rdM                  <= rdE;
        end
    end

    // Writeback stage: take Memory, register-file writes gated by valid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validW             <= 1'b0;
            resultSelectorW    <= 1'b0;
            writeEnableScalarW <= 1'b0;
            writeEnableVectorW <= 1'b0;
            rdW                <= '0;
        end else if (!holdAll) begin
            validW             <= validM;
            resultSelectorW    <= resultSelectorM;
            writeEnableScalarW <= validM & writeEnableScalarM;
            writeEnableVectorW <= validM & writeEnableVectorM;
            rdW                <= rdM;
        end
    end

    // Retire counter: one per valid output-flag op leaving Memory; wraps silently
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outFlagCount <= '0;
        end else if (!holdAll && validM && outFlagM) begin
            outFlagCount <= outFlagCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_control_stage_pipeline.sv
// Directed testbench for control_stage_pipeline: straight flow, load-use
// stall, freeze, hold during hazard, counter wrap, invalid masking, reset.
module tb_control_stage_pipeline;

    logic       clk;
    logic       reset;
    logic       validD;
    logic       isScalarInstructionD;
    logic       isVectorScalarOperationD;
    logic       useInmediateD;
    logic [2:0] aluControlD;
    logic       writeToMemoryEnableD;
    logic       outFlagD;
    logic       resultSelectorD;
    logic       writeEnableScalarD;
    logic       writeEnableVectorD;
    logic [3:0] rdD;
    logic [3:0] rs1D;
    logic [3:0] rs2D;
    logic       holdAll;
    logic       stallD;
    logic       validE;
    logic       isScalarInstructionE;
    logic       isVectorScalarOperationE;
    logic       useInmediateE;
    logic [2:0] aluControlE;
    logic       validM;
    logic       writeToMemoryEnableM;
    logic       outFlagM;
    logic       validW;
    logic       resultSelectorW;
    logic       writeEnableScalarW;
    logic       writeEnableVectorW;
    logic [3:0] rdW;
    logic [3:0] outFlagCount;

    int assertionCount = 0;
    int failureCount   = 0;

    control_stage_pipeline #(
        .REG_ADDR_WIDTH(4),
        .COUNT_WIDTH(4)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .validD                   (validD),
        .isScalarInstructionD     (isScalarInstructionD),
        .isVectorScalarOperationD (isVectorScalarOperationD),
        .useInmediateD            (useInmediateD),
        .aluControlD              (aluControlD),
        .writeToMemoryEnableD     (writeToMemoryEnableD),
        .outFlagD                 (outFlagD),
        .resultSelectorD          (resultSelectorD),
        .writeEnableScalarD       (writeEnableScalarD),
        .writeEnableVectorD       (writeEnableVectorD),
        .rdD                      (rdD),
        .rs1D                     (rs1D),
        .rs2D                     (rs2D),
        .holdAll                  (holdAll),
        .stallD                   (stallD),
        .validE                   (validE),
        .isScalarInstructionE     (isScalarInstructionE),
        .isVectorScalarOperationE (isVectorScalarOperationE),
        .useInmediateE            (useInmediateE),
        .aluControlE              (aluControlE),
        .validM                   (validM),
        .writeToMemoryEnableM     (writeToMemoryEnableM),
        .outFlagM                 (outFlagM),
        .validW                   (validW),
        .resultSelectorW          (resultSelectorW),
        .writeEnableScalarW       (writeEnableScalarW),
        .writeEnableVectorW       (writeEnableVectorW),
        .rdW                      (rdW),
        .outFlagCount             (outFlagCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports any mismatch
    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertionCount++;
        if (observed !== expected) begin
            failureCount++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end else begin
            $display("ok   %s = %0h", tag, observed);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearD();
        validD                   = 1'b0;
        isScalarInstructionD     = 1'b0;
        isVectorScalarOperationD = 1'b0;
        useInmediateD            = 1'b0;
        aluControlD              = 3'd0;
        writeToMemoryEnableD     = 1'b0;
        outFlagD                 = 1'b0;
        resultSelectorD          = 1'b0;
        writeEnableScalarD       = 1'b0;
        writeEnableVectorD       = 1'b0;
        rdD                      = 4'd0;
        rs1D                     = 4'd0;
        rs2D                     = 4'd0;
    endtask

    task automatic driveOp(input logic [2:0] alu, input logic weS, input logic weV,
                           input logic resSel, input logic oflag,
                           input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
        clearD();
        validD               = 1'b1;
        isScalarInstructionD = 1'b1;
        aluControlD          = alu;
        writeEnableScalarD   = weS;
        writeEnableVectorD   = weV;
        resultSelectorD      = resSel;
        outFlagD             = oflag;
        rdD                  = rd;
        rs1D                 = rs1;
        rs2D                 = rs2;
    endtask

    task automatic drain();
        clearD();
        repeat (3) tick();
    endtask

    initial begin
        reset   = 1'b0;
        holdAll = 1'b0;
        clearD();
        repeat (2) tick();

        // Reset state
        checkValue("rst_validE", 32'(validE), 1'b0);
        checkValue("rst_validW", 32'(validW), 1'b0);
        checkValue("rst_stallD", 32'(stallD), 1'b0);
        checkValue("rst_count", 32'(outFlagCount), 4'd0);
        reset = 1'b1;
        tick();

        // Straight flow: alu=001, scalar write to r5
        driveOp(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 4'd0);
        tick();
        checkValue("flow_aluE", 32'(aluControlE), 3'b001);
        checkValue("flow_validE", 32'(validE), 1'b1);
        clearD();
        tick();
        checkValue("flow_validM", 32'(validM), 1'b1);
        checkValue("flow_validE_off", 32'(validE), 1'b0);
        tick();
        checkValue("flow_weScalarW", 32'(writeEnableScalarW), 1'b1);
        checkValue("flow_rdW", 32'(rdW), 4'd5);
        tick();
        checkValue("flow_weScalarW_off", 32'(writeEnableScalarW), 1'b0);
        checkValue("flow_validW_off", 32'(validW), 1'b0);

        // Load-use: vector load to r3, consumer reads r3 via rs2
        driveOp(3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 4'd0, 4'd0);
        #1 checkValue("lu_noStallBeforeLoad", 32'(stallD), 1'b0);
        tick();
        driveOp(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 4'd0, 4'd3);
        #1 checkValue("lu_stall", 32'(stallD), 1'b1);
        tick();
        checkValue("lu_bubbleE", 32'(validE), 1'b0);
        checkValue("lu_loadInM", 32'(validM), 1'b1);
        checkValue("lu_stallCleared", 32'(stallD), 1'b0);
        tick();
        checkValue("lu_consumerE", 32'(validE), 1'b1);
        checkValue("lu_consumerAlu", 32'(aluControlE), 3'b010);
        drain();

        // Same load, consumer with rs1=rs2=4: no stall
        driveOp(3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 4'd0, 4'd0);
        tick();
        driveOp(3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8, 4'd4, 4'd4);
        #1 checkValue("nolu_stall", 32'(stallD), 1'b0);
        tick();
        checkValue("nolu_consumerE", 32'(validE), 1'b1);
        checkValue("nolu_aluE", 32'(aluControlE), 3'b011);
        drain();

        // Freeze with three valid stages; op B carries outFlag
        driveOp(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 4'd0);
        tick();
        driveOp(3'b011, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd0, 4'd0);
        tick();
        driveOp(3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 4'd0, 4'd0);
        tick();
        driveOp(3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 4'd0, 4'd0);
        holdAll = 1'b1;
        #1 checkValue("frz_stallD", 32'(stallD), 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkValue("frz_aluE", 32'(aluControlE), 3'b100);
            checkValue("frz_outFlagM", 32'(outFlagM), 1'b1);
            checkValue("frz_rdW", 32'(rdW), 4'd1);
            checkValue("frz_count", 32'(outFlagCount), 4'd0);
        end
        holdAll = 1'b0;
        tick();
        checkValue("frz_resume_aluE", 32'(aluControlE), 3'b101);
        checkValue("frz_resume_rdW", 32'(rdW), 4'd2);
        checkValue("frz_resume_count", 32'(outFlagCount), 4'd1);
        drain();

        // Freeze during a hazard: no bubble until the freeze lifts
        driveOp(3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 4'd0, 4'd0);
        tick();
        driveOp(3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 4'd10, 4'd9, 4'd0);
        holdAll = 1'b1;
        tick();
        checkValue("hh_loadHeldE", 32'(validE), 1'b1);
        checkValue("hh_noAdvanceM", 32'(validM), 1'b0);
        holdAll = 1'b0;
        #1 checkValue("hh_stallAfterFreeze", 32'(stallD), 1'b1);
        tick();
        checkValue("hh_bubbleE", 32'(validE), 1'b0);
        checkValue("hh_loadM", 32'(validM), 1'b1);
        tick();
        checkValue("hh_consumerAlu", 32'(aluControlE), 3'b110);
        drain();

        // Counter wrap: 16 more outFlag ops with bubbles between -> 17 total
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) driveOp(3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 4'd11, 4'd0, 4'd0);
            else            clearD();
            tick();
        end
        drain();
        checkValue("wrap_count", 32'(outFlagCount), 4'd1);

        // Invalid masking: validD=0 with every field set
        validD                   = 1'b0;
        isScalarInstructionD     = 1'b1;
        isVectorScalarOperationD = 1'b1;
        useInmediateD            = 1'b1;
        aluControlD              = 3'b111;
        writeToMemoryEnableD     = 1'b1;
        outFlagD                 = 1'b1;
        resultSelectorD          = 1'b1;
        writeEnableScalarD       = 1'b1;
        writeEnableVectorD       = 1'b1;
        rdD                      = 4'hF;
        rs1D                     = 4'hF;
        rs2D                     = 4'hF;
        tick();
        checkValue("inv_validE", 32'(validE), 1'b0);
        checkValue("inv_aluE", 32'(aluControlE), 3'b000);
        checkValue("inv_useImmE", 32'(useInmediateE), 1'b0);
        tick();
        checkValue("inv_memWrM", 32'(writeToMemoryEnableM), 1'b0);
        checkValue("inv_outFlagM", 32'(outFlagM), 1'b0);
        tick();
        checkValue("inv_weScalarW", 32'(writeEnableScalarW), 1'b0);
        checkValue("inv_weVectorW", 32'(writeEnableVectorW), 1'b0);
        checkValue("inv_stallD", 32'(stallD), 1'b0);
        checkValue("inv_count", 32'(outFlagCount), 4'd1);

        // Reset mid-stream with three valid ops in flight
        driveOp(3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 4'd0);
        tick();
        driveOp(3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd0, 4'd0);
        tick();
        driveOp(3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0, 4'd0);
        tick();
        checkValue("mid_preW", 32'(writeEnableScalarW), 1'b1);
        #2 reset = 1'b0;
        #1;
        checkValue("mid_validE", 32'(validE), 1'b0);
        checkValue("mid_validM", 32'(validM), 1'b0);
        checkValue("mid_validW", 32'(validW), 1'b0);
        checkValue("mid_weScalarW", 32'(writeEnableScalarW), 1'b0);
        checkValue("mid_outFlagM", 32'(outFlagM), 1'b0);
        checkValue("mid_count", 32'(outFlagCount), 4'd0);
        clearD();
        tick();
        reset = 1'b1;
        tick();
        checkValue("post_validE", 32'(validE), 1'b0);
        checkValue("post_validW", 32'(validW), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failureCount);
        $finish;
    end

endmodule

// File: doc/control_stage_pipeline.md
Name: control_stage_pipeline

Overview:
- Receiving end of the decode-stage control bundle produced by the opcode decoder.
- Registers the bundle through the Execute, Memory and Writeback stages, and gates each stage's side-effect enables with that stage's valid bit.
- Detects load-use hazards on memory-result instructions, stalls Decode for them, and inserts bubbles into Execute.
- Counts retired output-flag operations for the debug/IO path.

Parameters:
REG_ADDR_WIDTH, 4, register address width (scalar and vector files share the encoding)
COUNT_WIDTH, 16, width of the output-flag retire counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-low reset; all state cleared while low
validD  input  1  Decode holds a real instruction
isScalarInstructionD  input  1  scalar-datapath instruction
isVectorScalarOperationD  input  1  vector op with scalar/immediate operand
useInmediateD  input  1  ALU B operand from immediate
aluControlD  input  3  ALU operation
writeToMemoryEnableD  input  1  memory store
outFlagD  input  1  output/flag operation in Memory stage
resultSelectorD  input  1  writeback takes memory data (1) or ALU result (0)
writeEnableScalarD  input  1  scalar register-file write
writeEnableVectorD  input  1  vector register-file write
rdD  input  REG_ADDR_WIDTH  destination register
rs1D, rs2D  input  REG_ADDR_WIDTH each  source registers
holdAll  input  1  global freeze (memory wait)
stallD  output  1  Fetch/Decode must hold their current instruction
validE, isScalarInstructionE, isVectorScalarOperationE, useInmediateE  output  1 each  Execute-stage fields
aluControlE  output  3  Execute-stage ALU operation
validM, writeToMemoryEnableM, outFlagM  output  1 each  Memory-stage fields
validW, resultSelectorW, writeEnableScalarW, writeEnableVectorW  output  1 each  Writeback-stage fields
rdW  output  REG_ADDR_WIDTH  Writeback destination register
outFlagCount  output  COUNT_WIDTH  retired output-flag operations

Behaviour:
- State: three stage registers, E, M and W. Each holds valid, the control fields consumed at or after that stage, and rd. Plus the counter.
- Reset (reset=0, asynchronous):
  - every output register is 0: all valid bits, all fields, rd, outFlagCount.
  - stallD is 0 because it is combinational on cleared state.
- Release is synchronous to the next rising clk. Reset asserted mid-instruction discards all in-flight work, with no partial writeback.
- Advance latency: the D bundle appears at E outputs 1 cycle later, at M 2 cycles later, at W 3 cycles later.
- Load-use hazard (combinational):
  - hazard = validD & validE & resultSelectorE & (writeEnableScalarE | writeEnableVectorE) & (rs1D==rdE | rs2D==rdE).
  - The comparison is address-only, with no register-file qualification. It is conservative by design.
- stallD = hazard | holdAll.
- Priority per clock edge, highest first:
  1. holdAll=1: E, M, W and the counter all hold their values.
  2. hazard=1: E loads a bubble (valid=0, all fields 0). M takes the old E, W takes the old M.
  3. Otherwise: E takes D and is valid only if validD. M takes E, W takes M.
- Invalid bubbles: when validD=0, E is loaded with all fields 0 regardless of the D field values.
- Enable gating: writeToMemoryEnableM, outFlagM, writeEnableScalarW and writeEnableVectorW are each stored ANDed with their stage valid. An invalid stage never asserts an enable.
- Counter:
  - increments by 1 on an edge where validM & outFlagM & !holdAll.
  - wraps modulo 2^COUNT_WIDTH from all-ones to 0 with no flag.
- Hazard resolution: a hazard lasts exactly 1 cycle per producer. After the bubble, the producer sits in M and the source is forwarded/read normally. Two consecutive dependent consumers each see at most one stall.
- Simultaneous events:
  - holdAll during a hazard: freeze wins, no bubble is inserted, and the hazard re-evaluates after the freeze.
  - A hazard with validD=0 is impossible by the definition above.

Test Plan:
- Reset mid-stream: 3 valid ALU ops in flight, pull reset low between edges -> all valid/enable outputs and outFlagCount read 0 immediately, before the next edge.
- Straight flow: opcode bundle with aluControlD=3'b001, writeEnableScalarD=1, rdD=5 for 1 cycle -> aluControlE=001 at +1; validM=1 at +2; writeEnableScalarW=1, rdW=5 at +3, deasserted at +4.
- Load-use: load with resultSelectorD=1, writeEnableVectorD=1, rdD=3, followed by an op with rs2D=3 -> stallD=1 for exactly 1 cycle; validE=0 bubble; consumer reaches E 2 cycles after the load; no stall if rs1D=rs2D=4.
- Freeze: holdAll=1 for 4 cycles with 3 valid stages -> E/M/W outputs unchanged, stallD=1, counter unchanged; flow resumes identically after release.
- Counter wrap: COUNT_WIDTH=4, retire 17 outFlag ops, invalid bubbles interleaved -> outFlagCount=1; bubbles and held cycles never count.
- Invalid masking: validD=0 with all D fields 1 -> validE=0, aluControlE=0, and no enables ever asserted downstream.
